// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: 3-stage pipelined floating-point multiplier with a valid/ready handshake.
// Subnormal inputs are flushed to zero. Rounding is to nearest, ties to even.
// The defaults give binary32.
//
// Ports
//   clk, rst             single clock; synchronous active-high reset
//   in_valid/in_ready    operand handshake for a, b ({sign, exp, frac})
//   out_valid/out_ready  result handshake for result, flags
//   flags                {invalid, overflow, underflow, inexact}, qualified by out_valid
//
// Pipeline: S1 unpack/classify -> S2 significand product -> S3 normalise -> output register
// (round and pack). One global enable advances every stage together, so a stalled output
// freezes the whole pipe and nothing is dropped.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   flags
);

  localparam int unsigned EW2  = EXP_W + 2;
  localparam int unsigned SW   = MAN_W + 1;
  localparam int unsigned PW   = 2 * MAN_W + 2;
  localparam int unsigned BIAS = (1 << (EXP_W - 1)) - 1;

  localparam logic [EW2-1:0] BiasE = EW2'(BIAS);
  localparam logic [EW2-1:0] EMax  = EW2'((1 << EXP_W) - 1);
  localparam logic [EW2-1:0] EOne  = EW2'(1);
  localparam logic [EW2-1:0] EZero = '0;
  localparam logic [W-1:0]   QNan  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} cls_e;

  logic en;

  // S1 registers
  logic           s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
  cls_e           s1_cls_q, s1_cls_d;
  logic [SW-1:0]  s1_sig_a_q, s1_sig_a_d, s1_sig_b_q, s1_sig_b_d;
  logic [EW2-1:0] s1_e_q, s1_e_d;
  // S2 registers
  logic           s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d;
  cls_e           s2_cls_q, s2_cls_d;
  logic [EW2-1:0] s2_e_q, s2_e_d;
  logic [PW-1:0]  s2_prod_q, s2_prod_d;
  // S3 registers
  logic           s3_valid_q, s3_valid_d, s3_sign_q, s3_sign_d;
  cls_e           s3_cls_q, s3_cls_d;
  logic [EW2-1:0] s3_e_q, s3_e_d;
  logic [SW-1:0]  s3_mant_q, s3_mant_d;
  logic           s3_guard_q, s3_guard_d, s3_sticky_q, s3_sticky_d;
  // Output registers
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   result_q, result_d;
  logic [3:0]     flags_q, flags_d;

  // Unpack / classify
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  cls_e             in_cls;

  always_comb begin
    ea     = a[W-2:MAN_W];
    eb     = b[W-2:MAN_W];
    fa     = a[MAN_W-1:0];
    fb     = b[MAN_W-1:0];
    a_nan  = (&ea) && (|fa);
    a_inf  = (&ea) && !(|fa);
    a_zero = (ea == '0);
    b_nan  = (&eb) && (|fb);
    b_inf  = (&eb) && !(|fb);
    b_zero = (eb == '0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      in_cls = ClsNan;
    end else if (a_inf || b_inf) begin
      in_cls = ClsInf;
    end else if (a_zero || b_zero) begin
      in_cls = ClsZero;
    end else begin
      in_cls = ClsNorm;
    end
  end

  // Normalise the product: a set MSB means the significand lies in [2,4).
  logic [SW-1:0]  norm_mant;
  logic           norm_guard, norm_sticky;
  logic [EW2-1:0] norm_e;

  always_comb begin
    if (s2_prod_q[PW-1]) begin
      norm_mant   = s2_prod_q[PW-1:MAN_W+1];
      norm_guard  = s2_prod_q[MAN_W];
      norm_sticky = |s2_prod_q[MAN_W-1:0];
      norm_e      = s2_e_q + EOne;
    end else begin
      norm_mant   = s2_prod_q[PW-2:MAN_W];
      norm_guard  = s2_prod_q[MAN_W-1];
      norm_sticky = |s2_prod_q[MAN_W-2:0];
      norm_e      = s2_e_q;
    end
  end

  // Round to nearest even, then select special / range-limited / normal result.
  logic           round_up;
  logic [SW:0]    rnd_sum;
  logic [MAN_W-1:0] rnd_frac;
  logic [EW2-1:0] rnd_e;
  logic [W-1:0]   pack_res;
  logic [3:0]     pack_flags;

  always_comb begin
    round_up = s3_guard_q && (s3_sticky_q || s3_mant_q[0]);
    rnd_sum  = {1'b0, s3_mant_q} + (SW+1)'(round_up);
    if (rnd_sum[SW]) begin
      // Carry out of the significand: value is exactly 2.0, renormalise.
      rnd_frac = rnd_sum[MAN_W:1];
      rnd_e    = s3_e_q + EOne;
    end else begin
      rnd_frac = rnd_sum[MAN_W-1:0];
      rnd_e    = s3_e_q;
    end

    pack_res   = '0;
    pack_flags = '0;
    unique case (s3_cls_q)
      ClsNan: begin
        pack_res   = QNan;
        pack_flags = 4'b1000;
      end
      ClsInf: begin
        pack_res = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
      ClsZero: begin
        pack_res = {s3_sign_q, {(W-1){1'b0}}};
      end
      ClsNorm: begin
        if ($signed(rnd_e) >= $signed(EMax)) begin
          pack_res   = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          pack_flags = 4'b0101;
        end else if ($signed(rnd_e) <= $signed(EZero)) begin
          pack_res   = {s3_sign_q, {(W-1){1'b0}}};
          pack_flags = 4'b0011;
        end else begin
          pack_res   = {s3_sign_q, rnd_e[EXP_W-1:0], rnd_frac};
          pack_flags = {3'b000, s3_guard_q | s3_sticky_q};
        end
      end
    endcase
  end

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en && !rst;

  // Next state: every stage holds unless the global enable is high.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_cls_d    = s1_cls_q;
    s1_sig_a_d  = s1_sig_a_q;
    s1_sig_b_d  = s1_sig_b_q;
    s1_e_d      = s1_e_q;
    s2_valid_d  = s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_cls_d    = s2_cls_q;
    s2_e_d      = s2_e_q;
    s2_prod_d   = s2_prod_q;
    s3_valid_d  = s3_valid_q;
    s3_sign_d   = s3_sign_q;
    s3_cls_d    = s3_cls_q;
    s3_e_d      = s3_e_q;
    s3_mant_d   = s3_mant_q;
    s3_guard_d  = s3_guard_q;
    s3_sticky_d = s3_sticky_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (en) begin
      s1_valid_d  = in_valid && in_ready;
      s1_sign_d   = a[W-1] ^ b[W-1];
      s1_cls_d    = in_cls;
      s1_sig_a_d  = {1'b1, fa};
      s1_sig_b_d  = {1'b1, fb};
      s1_e_d      = {2'b00, ea} + {2'b00, eb} - BiasE;
      s2_valid_d  = s1_valid_q;
      s2_sign_d   = s1_sign_q;
      s2_cls_d    = s1_cls_q;
      s2_e_d      = s1_e_q;
      s2_prod_d   = PW'(s1_sig_a_q) * PW'(s1_sig_b_q);
      s3_valid_d  = s2_valid_q;
      s3_sign_d   = s2_sign_q;
      s3_cls_d    = s2_cls_q;
      s3_e_d      = norm_e;
      s3_mant_d   = norm_mant;
      s3_guard_d  = norm_guard;
      s3_sticky_d = norm_sticky;
      out_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        result_d = pack_res;
        flags_d  = pack_flags;
      end
    end
  end

  // Only the valids and the visible outputs need reset; datapath flops just follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s3_valid_q  <= s3_valid_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
    s1_sign_q   <= s1_sign_d;
    s1_cls_q    <= s1_cls_d;
    s1_sig_a_q  <= s1_sig_a_d;
    s1_sig_b_q  <= s1_sig_b_d;
    s1_e_q      <= s1_e_d;
    s2_sign_q   <= s2_sign_d;
    s2_cls_q    <= s2_cls_d;
    s2_e_q      <= s2_e_d;
    s2_prod_q   <= s2_prod_d;
    s3_sign_q   <= s3_sign_d;
    s3_cls_q    <= s3_cls_d;
    s3_e_q      <= s3_e_d;
    s3_mant_q   <= s3_mant_d;
    s3_guard_q  <= s3_guard_d;
    s3_sticky_q <= s3_sticky_d;
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe (binary32). Directed vectors carry hand-derived expected values;
// random vectors use an exact-integer reference multiply. Every transferred operand is queued
// and the queue front is compared with result/flags on every cycle out_valid is high.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [35:0] exp_q[$];
  logic [35:0] next_exp;
  bit          acc;

  // Directed vectors: {a, b} and expected {result, flags}.
  logic [31:0] dir_a [12] = '{32'h3F800000, 32'h3E800000, 32'h4F000000, 32'h00000000,
                              32'h7F800000, 32'hFF800000, 32'h7FC00001, 32'h7F000000,
                              32'h00800000, 32'h00000001, 32'h3FC00000, 32'h80000000};
  logic [31:0] dir_b [12] = '{32'h40000000, 32'h3E800000, 32'h4F000000, 32'h3F800000,
                              32'h00000000, 32'h40000000, 32'h3F800000, 32'h7F000000,
                              32'h00800000, 32'h7F000000, 32'h3F800001, 32'h3F800000};
  logic [35:0] dir_e [12] = '{{32'h40000000, 4'b0000}, {32'h3D800000, 4'b0000},
                              {32'h5E800000, 4'b0000}, {32'h00000000, 4'b0000},
                              {32'h7FC00000, 4'b1000}, {32'hFF800000, 4'b0000},
                              {32'h7FC00000, 4'b1000}, {32'h7F800000, 4'b0101},
                              {32'h00000000, 4'b0011}, {32'h00000000, 4'b0000},
                              {32'h3FC00002, 4'b0001}, {32'h80000000, 4'b0000}};

  // Reference: exact integer product, then round by comparing the discarded remainder with half.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic            s;
    int              ex, ey, e, sh;
    longint unsigned mx, my, p, q, rem, half;
    logic            inex;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    if ((ex == 255 && x[22:0] != 0) || (ey == 255 && y[22:0] != 0) ||
        (ex == 255 && ey == 0) || (ey == 255 && ex == 0))
      return {32'h7FC00000, 4'b1000};
    if (ex == 255 || ey == 255) return {s, 8'hFF, 23'h0, 4'b0000};
    if (ex == 0 || ey == 0) return {s, 31'h0, 4'b0000};
    mx = 64'h80_0000 | {41'h0, x[22:0]};
    my = 64'h80_0000 | {41'h0, y[22:0]};
    p  = mx * my;
    e  = ex + ey - 127;
    if (p >= 64'h8000_0000_0000) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inex = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 64'h100_0000) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0) return {s, 31'h0, 4'b0011};
    return {s, 8'(e), q[22:0], 3'b000, inex};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] sp [7] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                            32'h7FC00000, 32'h00000001, 32'h00800000};
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return sp[$urandom_range(0, 6)];
      default: return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes on the falling edge, then return 1 time unit after the rise.
  task automatic tick(output bit accepted);
    @(negedge clk);
    accepted = (in_valid === 1'b1) && (in_ready === 1'b1);
    if (accepted) exp_q.push_back(next_exp);
    if (out_valid === 1'b1) begin
      check("out_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("result", 64'(result), 64'(exp_q[0][35:4]));
        check("flags", 64'(flags), 64'(exp_q[0][3:0]));
        if (out_ready === 1'b1) void'(exp_q.pop_front());
      end
      if (out_ready === 1'b0) check("in_ready_bp", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(acc);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Accept one operand, then expect out_valid exactly after the third following edge.
  task automatic latency_op(input logic [31:0] x, input logic [31:0] y, input logic [35:0] e);
    in_valid = 1'b1;
    a        = x;
    b        = y;
    next_exp = e;
    tick(acc);
    check("lat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("lat_early", 64'(out_valid), 64'd0);
      tick(acc);
    end
    check("lat_valid", 64'(out_valid), 64'd1);
    drain();
  endtask

  initial begin
    int sent, cyc;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 32'h3F800000;
    b         = 32'h3F800000;
    next_exp  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    rst      = 1'b0;

    latency_op(dir_a[0], dir_b[0], dir_e[0]);

    // Directed vectors back to back.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      a        = dir_a[i];
      b        = dir_b[i];
      next_exp = dir_e[i];
      tick(acc);
      check("dir_accept", 64'(acc), 64'd1);
    end
    drain();

    // Eight back-to-back ops with a 5-cycle output stall in the middle.
    sent = 0;
    cyc  = 0;
    a    = rnd_op();
    b    = rnd_op();
    while (sent < 8 && cyc < 100) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = 1'b1;
      next_exp  = ref_mul(a, b);
      tick(acc);
      if (acc) begin
        sent++;
        a = rnd_op();
        b = rnd_op();
      end
      cyc++;
    end
    check("stream_sent", 64'(sent), 64'd8);
    out_ready = 1'b1;
    drain();

    // Random traffic with random backpressure.
    sent = 0;
    cyc  = 0;
    a    = rnd_op();
    b    = rnd_op();
    while (sent < 300 && cyc < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 4) != 0);
      next_exp  = ref_mul(a, b);
      tick(acc);
      if (acc) begin
        sent++;
        a = rnd_op();
        b = rnd_op();
      end
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd300);
    out_ready = 1'b1;
    drain();

    // Reset with three ops in flight: none of them may appear.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = rnd_op();
      b        = rnd_op();
      next_exp = ref_mul(a, b);
      tick(acc);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick(acc);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      check("rst_flushed", 64'(out_valid), 64'd0);
    end
    a = rnd_op();
    b = rnd_op();
    latency_op(a, b, ref_mul(a, b));
    latency_op(32'h3FC00000, 32'h3F800001, {32'h3FC00002, 4'b0001});

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: observed no finish, expected finish before 1000000");
    $fatal(1, "timeout");
  end

endmodule
